// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement A - B, LSB first.
// One full-subtractor cell plus a borrow flop. An operation is accepted
// from IDLE and finishes WIDTH edges later with a one-cycle done pulse.
// The registered borrow/zero/overflow flags and diff hold until the next op.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_borrow, r_zero, r_ovf;

  logic             w_ai, w_bi, w_d, w_bw_nxt, w_last, w_ovf;
  logic [WIDTH-1:0] w_diff_nxt;

  // Full-subtractor cell on the current LSBs. On the last bit the LSBs
  // hold the original operand MSBs, so signed overflow is formed here.
  always_comb begin
    w_ai       = r_a[0];
    w_bi       = r_b[0];
    w_d        = w_ai ^ w_bi ^ r_bw;
    w_bw_nxt   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bw);
    w_diff_nxt = {w_d, r_diff[WIDTH-1:1]};
    w_last     = (r_cnt == CW'(WIDTH - 1));
    w_ovf      = (w_ai ^ w_bi) & (w_d ^ w_ai);
  end

  // Control: accept in IDLE, count WIDTH bit cycles in RUN, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand shift registers, borrow flop and diff shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_bw   <= 1'b0;
      r_diff <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_a  <= a;
        r_b  <= b;
        r_bw <= 1'b0;
      end
    end else begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_bw   <= w_bw_nxt;
      r_diff <= w_diff_nxt;
    end
  end

  // Flags are captured only on the final bit edge and held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_borrow <= w_bw_nxt;
      r_zero   <= ~|w_diff_nxt;
      r_ovf    <= w_ovf;
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule
